modn_updown_counter: RTL and testbench

Parametrised modulo-N up/down counter with synchronous load, count enable, terminal-count flag and wrap/load-error event pulses. Next-generation replacement for the fixed modulo-15 counter: width and modulus are parameters, wrap-around is correct in both directions, and out-of-range loads are rejected. Intended for timers, divider chains and address sequencers in the same clock domain.

---
 rtl/modn_updown_counter.sv | 116 +++++++++++
 tb/tb_modn_updown_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modn_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : modn_updown_counter
//  Purpose  : Parametrised modulo-N up/down counter with synchronous load,
//             count enable, terminal-count flag and one-cycle wrap and
//             load-error pulses.
//  Ports    : clk      - clock, all state updates on the rising edge
//             rst      - synchronous active-low reset
//             en       - count enable (load is honoured even when low)
//             mode     - direction: 1 = up, 0 = down
//             load     - synchronous load request
//             data     - load value (rejected when >= MODULUS)
//             data_out - registered count, always within 0..MODULUS-1
//             tc       - terminal count, combinational from data_out/mode
//             wrap     - registered pulse: a wrap happened on the last edge
//             load_err - registered pulse: the last load was rejected
//  Params   : WIDTH   (2..16)         counter width
//             MODULUS (2..2**WIDTH)   count range 0..MODULUS-1
//  Options  : MODN_CNT_SAT_EN - when defined the counter saturates at its
//             end value instead of wrapping, and wrap is never raised.
//  Revision : 1.0 - initial release
// ============================================================================
module modn_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Modulus is held at WIDTH+1 bits so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   c_mod = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-1:0] w_next;
  logic             w_wrap_next;
  logic             w_err_next;
  logic             w_load_ok;
  logic             w_at_top;
  logic             w_at_bot;

  assign w_load_ok = ({1'b0, data} < c_mod);
  assign w_at_top  = (r_count == c_max);
  assign w_at_bot  = (r_count == '0);

  // End values are tested before stepping, so the increment never reaches
  // MODULUS and the decrement never underflows.
  always_comb begin
    w_next      = r_count;
    w_wrap_next = 1'b0;
    w_err_next  = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        w_next = data;
      end else begin
        w_err_next = 1'b1;
      end
    end else if (en) begin
      if (mode) begin
        if (w_at_top) begin
`ifdef MODN_CNT_SAT_EN
          w_next      = r_count;
`else
          w_next      = '0;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_next = r_count + c_one;
        end
      end else begin
        if (w_at_bot) begin
`ifdef MODN_CNT_SAT_EN
          w_next      = r_count;
`else
          w_next      = c_max;
          w_wrap_next = 1'b1;
`endif
        end else begin
          w_next = r_count - c_one;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_wrap_next;
      r_err   <= w_err_next;
    end
  end

  assign data_out = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_err;
  assign tc       = mode ? w_at_top : w_at_bot;

endmodule
`default_nettype wire

// File: tb/tb_modn_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modn_updown_counter
//  Purpose  : Self-checking bench for modn_updown_counter. Two instances
//             (MODULUS 15 and 16, WIDTH 4) share the same stimulus and are
//             compared against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_modn_updown_counter;

  localparam int WIDTH = 4;
  localparam int NDUT  = 2;
  localparam int MODS [NDUT] = '{15, 16};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             mode = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] data = '0;

  logic [WIDTH-1:0] q    [NDUT];
  logic             tcs  [NDUT];
  logic             wr   [NDUT];
  logic             le   [NDUT];

  int m_cnt  [NDUT];
  int m_wrap [NDUT];
  int m_err  [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modn_updown_counter #(.WIDTH(WIDTH), .MODULUS(15)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .data(data),
    .data_out(q[0]), .tc(tcs[0]), .wrap(wr[0]), .load_err(le[0])
  );

  modn_updown_counter #(.WIDTH(WIDTH), .MODULUS(16)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .data(data),
    .data_out(q[1]), .tc(tcs[1]), .wrap(wr[1]), .load_err(le[1])
  );

  // Reference model: plain modular arithmetic on integers.
  task automatic model_step();
    for (int k = 0; k < NDUT; k++) begin
      int m;
      m = MODS[k];
      m_wrap[k] = 0;
      m_err[k]  = 0;
      if (!rst) begin
        m_cnt[k] = 0;
      end else if (load) begin
        if (int'(data) < m) m_cnt[k] = int'(data);
        else                m_err[k] = 1;
      end else if (en) begin
`ifdef MODN_CNT_SAT_EN
        if (mode) m_cnt[k] = (m_cnt[k] + 1 >= m) ? m - 1 : m_cnt[k] + 1;
        else      m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
`else
        if (mode) begin
          m_wrap[k] = (m_cnt[k] + 1 == m) ? 1 : 0;
          m_cnt[k]  = (m_cnt[k] + 1) % m;
        end else begin
          m_wrap[k] = (m_cnt[k] == 0) ? 1 : 0;
          m_cnt[k]  = (m_cnt[k] + m - 1) % m;
        end
`endif
      end
    end
  endtask

  function automatic int model_tc(int k);
    return mode ? int'(m_cnt[k] == MODS[k] - 1) : int'(m_cnt[k] == 0);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; load = 1'b1; data = 4'd5; mode = 1'b1;
    tick();
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (q[k] !== '0 || wr[k] !== 1'b0 || le[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: q=%0d wrap=%b err=%b, want q=0 wrap=0 err=0",
                 k, q[k], wr[k], le[k]);
      end
      checks++;
      if (tcs[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_tc_up dut%0d: tc=%b want 0", k, tcs[k]);
      end
    end
    mode = 1'b0;
    #1;
    checks++;
    if (tcs[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_tc_down: tc=%b want 1", tcs[0]);
    end
    mode = 1'b1;
    tick();
  endtask

  task automatic test_count_up();
    rst = 1'b1; load = 1'b0; en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (int'(q[k]) != m_cnt[k] || int'(wr[k]) != m_wrap[k] ||
            int'(tcs[k]) != model_tc(k)) begin
          errors++;
          $display("FAIL count_up dut%0d step%0d: q=%0d wrap=%b tc=%b, want q=%0d wrap=%0d tc=%0d",
                   k, i, q[k], wr[k], tcs[k], m_cnt[k], m_wrap[k], model_tc(k));
        end
      end
    end
  endtask

  task automatic test_count_down();
    rst = 1'b0; tick();
    rst = 1'b1; en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (int'(q[0]) != m_cnt[0] || int'(wr[0]) != m_wrap[0] || q[0] === 4'd15) begin
        errors++;
        $display("FAIL count_down step%0d: q=%0d wrap=%b, want q=%0d wrap=%0d",
                 i, q[0], wr[0], m_cnt[0], m_wrap[0]);
      end
    end
  endtask

  task automatic test_load();
    en = 1'b1; mode = 1'b1; load = 1'b1; data = 4'd7;
    tick();
    checks++;
    if (q[0] !== 4'd7 || le[0] !== 1'b0) begin
      errors++;
      $display("FAIL load7: q=%0d err=%b, want q=7 err=0", q[0], le[0]);
    end
    data = 4'd3; tick();
    data = 4'd15; tick();
    checks++;
    if (q[0] !== 4'd3 || le[0] !== 1'b1 || wr[0] !== 1'b0) begin
      errors++;
      $display("FAIL load_reject: q=%0d err=%b wrap=%b, want q=3 err=1 wrap=0",
               q[0], le[0], wr[0]);
    end
    checks++;
    if (q[1] !== 4'd15 || le[1] !== 1'b0) begin
      errors++;
      $display("FAIL load15_mod16: q=%0d err=%b, want q=15 err=0", q[1], le[1]);
    end
    load = 1'b0; en = 1'b0; tick();
    checks++;
    if (le[0] !== 1'b0 || q[0] !== 4'd3) begin
      errors++;
      $display("FAIL load_err_pulse: err=%b q=%0d, want err=0 q=3", le[0], q[0]);
    end
  endtask

  task automatic test_mod16_wrap();
    load = 1'b1; data = 4'd15; tick();
    load = 1'b0; en = 1'b1; mode = 1'b1; tick();
    checks++;
    if (int'(q[1]) != m_cnt[1] || int'(wr[1]) != m_wrap[1]) begin
      errors++;
      $display("FAIL mod16_wrap: q=%0d wrap=%b, want q=%0d wrap=%0d",
               q[1], wr[1], m_cnt[1], m_wrap[1]);
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; data = 4'd9; tick();
    load = 1'b0; en = 1'b1; tick();
    rst = 1'b0; load = 1'b1; data = 4'd5; tick();
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (q[k] !== '0 || wr[k] !== 1'b0 || le[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid dut%0d: q=%0d wrap=%b err=%b, want 0 0 0",
                 k, q[k], wr[k], le[k]);
      end
    end
    rst = 1'b1; load = 1'b0; en = 1'b1; mode = 1'b1; tick();
    en = 1'b0; tick(); tick();
    checks++;
    if (q[0] !== 4'd1) begin
      errors++;
      $display("FAIL hold: q=%0d want 1", q[0]);
    end
    for (int i = 0; i < 4; i++) begin
      mode = ~mode;
      #1;
      checks++;
      if (int'(tcs[1]) != model_tc(1) || int'(tcs[0]) != model_tc(0)) begin
        errors++;
        $display("FAIL tc_toggle %0d: tc0=%b tc1=%b, want %0d %0d",
                 i, tcs[0], tcs[1], model_tc(0), model_tc(1));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 29) != 0);
      load = ($urandom_range(0, 5) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = ($urandom_range(0, 2) != 0) ? mode : ~mode;
      data = WIDTH'($urandom_range(0, 15));
      tick();
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (int'(q[k]) != m_cnt[k] || int'(wr[k]) != m_wrap[k] ||
            int'(le[k]) != m_err[k] || int'(tcs[k]) != model_tc(k)) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: q=%0d wrap=%b err=%b tc=%b, want q=%0d wrap=%0d err=%0d tc=%0d",
                   k, i, q[k], wr[k], le[k], tcs[k], m_cnt[k], m_wrap[k], m_err[k], model_tc(k));
        end
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_mod16_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
